// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control sequencer: walks each instruction through fetch, decode, execute,
// memory and writeback, handshaking with a variable-latency shared memory port.
module multi_cycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       illegal_instr,
    output logic       mem_timeout
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC_R, S_RWB,
        S_ADDR, S_MEM_RD, S_LWB, S_MEM_WR, S_BRANCH
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic               wait_expired;
    logic               r_legal;
    logic [3:0]         r_alu_op;

    // R-type funct decode, shared by DECODE (legality) and EXEC_R (ALU op)
    always_comb begin
        r_legal  = 1'b1;
        r_alu_op = ALU_ADD;
        case (funct)
            6'h20, 6'h21: r_alu_op = ALU_ADD;
            6'h22, 6'h23: r_alu_op = ALU_SUB;
            6'h24:        r_alu_op = ALU_AND;
            6'h25:        r_alu_op = ALU_OR;
            6'h26:        r_alu_op = ALU_XOR;
            6'h27:        r_alu_op = ALU_NOR;
            6'h2A:        r_alu_op = ALU_SLT;
            6'h2B:        r_alu_op = ALU_SLTU;
            default:      r_legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_START;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state and control decode; the wait counter only survives while stalled in a memory state
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = '0;
        wait_expired  = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        retire        = 1'b0;
        illegal_instr = 1'b0;
        mem_timeout   = 1'b0;

        case (state)
            S_START: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_expired) begin
                    mem_timeout = 1'b1;
                    state_nxt   = S_FETCH;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (opcode == 6'h00 && r_legal) begin
                    state_nxt = S_EXEC_R;
                end else if (opcode == 6'h23 || opcode == 6'h2B) begin
                    state_nxt = S_ADDR;
                end else if (opcode == 6'h04) begin
                    state_nxt = S_BRANCH;
                end else begin
                    illegal_instr = 1'b1;
                    state_nxt     = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
                state_nxt = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nxt = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_LWB;
                end else if (wait_expired) begin
                    mem_timeout = 1'b1;
                    state_nxt   = S_FETCH;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_LWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (wait_expired) begin
                    mem_timeout = 1'b1;
                    state_nxt   = S_FETCH;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = zero;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_START;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: a per-instruction reference model queues the expected
// control vector for every cycle, and a negedge monitor pops and compares against the DUT.
module tb_multi_cycle_control;

    localparam int unsigned MEM_TIMEOUT = 16;
    localparam logic [3:0]  A_ADD = 4'b0000;
    localparam logic [3:0]  A_SUB = 4'b0001;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       retire;
        logic       illegal_instr;
        logic       mem_timeout;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write, reg_dst, mem_to_reg, retire, illegal_instr, mem_timeout;

    ctl_t  exp_q[$];
    string name_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    exp_retires = 0;
    int    seen_retires = 0;

    multi_cycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .retire(retire), .illegal_instr(illegal_instr),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Monitor: every queued cycle is checked at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, retire,
                  illegal_instr, mem_timeout};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL %s @%0t: got %b expected %b", nm, $time, a, e);
            end
            if (retire === 1'b1) seen_retires++;
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 illegal, 1 R-type, 2 lw, 3 sw, 4 beq
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B) return 1;
            return 0;
        end
        if (op == 6'h23) return 2;
        if (op == 6'h2B) return 3;
        if (op == 6'h04) return 4;
        return 0;
    endfunction

    function automatic logic [3:0] r_op(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 4'b0000;
            6'h22, 6'h23: return 4'b0001;
            6'h24:        return 4'b0010;
            6'h25:        return 4'b0011;
            6'h26:        return 4'b0101;
            6'h27:        return 4'b0100;
            6'h2A:        return 4'b1001;
            default:      return 4'b1010;
        endcase
    endfunction

    task automatic do_cycle(input ctl_t e, input logic mr, input logic z, input string nm);
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // kind 0 fetch, 1 load, 2 store; wt = cycles of mem_ready low before it rises
    task automatic mem_access(input int kind, input int wt, input string nm, output bit done);
        ctl_t e;
        done = 1'b0;
        for (int c = 0; c < int'(MEM_TIMEOUT) && !done; c++) begin
            e = '0;
            e.mem_req = 1'b1;
            if (kind == 0) begin
                e.alu_src_b = 2'b01;
                e.alu_op    = A_ADD;
            end else begin
                e.i_or_d = 1'b1;
            end
            if (kind == 2) e.mem_write = 1'b1;
            if (c >= wt) begin
                if (kind == 0) begin
                    e.ir_write = 1'b1;
                    e.pc_write = 1'b1;
                end
                if (kind == 2) begin
                    e.retire = 1'b1;
                    exp_retires++;
                end
                done = 1'b1;
                do_cycle(e, 1'b1, rbit(), nm);
            end else begin
                if (c == int'(MEM_TIMEOUT) - 1) e.mem_timeout = 1'b1;
                do_cycle(e, 1'b0, rbit(), nm);
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input logic z);
        bit   done;
        ctl_t e;
        int   k;
        mem_access(0, fw, "fetch", done);
        if (!done) mem_access(0, 0, "refetch", done);
        opcode = op;
        funct  = fn;
        k = classify(op, fn);
        e = '0;
        e.alu_src_b = 2'b11;
        e.alu_op    = A_ADD;
        if (k == 0) e.illegal_instr = 1'b1;
        do_cycle(e, rbit(), rbit(), "decode");
        case (k)
            1: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = r_op(fn);
                do_cycle(e, rbit(), rbit(), "exec_r");
                e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1;
                exp_retires++;
                do_cycle(e, rbit(), rbit(), "rwb");
            end
            2, 3: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = A_ADD;
                do_cycle(e, rbit(), rbit(), "addr");
                if (k == 2) begin
                    mem_access(1, mw, "mem_rd", done);
                    if (done) begin
                        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1;
                        exp_retires++;
                        do_cycle(e, rbit(), rbit(), "lwb");
                    end
                end else begin
                    mem_access(2, mw, "mem_wr", done);
                end
            end
            4: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = A_SUB; e.pc_src = 1'b1;
                e.pc_write = z; e.retire = 1'b1;
                exp_retires++;
                do_cycle(e, rbit(), z, "branch");
            end
            default: ;
        endcase
    endtask

    function automatic int rnd_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 12) return 0;
        if (r < 18) return int'($urandom_range(1, 3));
        if (r == 18) return int'(MEM_TIMEOUT) - 1;
        return int'($urandom_range(MEM_TIMEOUT, MEM_TIMEOUT + 2));
    endfunction

    initial begin
        bit         done;
        ctl_t       e;
        logic [5:0] op, fn;
        int         r;
        logic [5:0] r_fns [10];
        r_fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

        reset_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
        repeat (2) @(posedge clk);
        #1;
        do_cycle('0, 1'b1, 1'b1, "in_reset");
        reset_n = 1'b1;
        do_cycle('0, 1'b1, 1'b1, "start");

        run_instr(6'h00, 6'h20, 0, 0, 1'b0);          // add
        run_instr(6'h23, 6'h00, 0, 3, 1'b0);          // lw, 3 wait cycles
        run_instr(6'h04, 6'h00, 0, 0, 1'b1);          // beq taken
        run_instr(6'h04, 6'h00, 0, 0, 1'b0);          // beq not taken
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0);          // illegal opcode
        run_instr(6'h00, 6'h01, 0, 0, 1'b0);          // illegal funct
        run_instr(6'h2B, 6'h00, 0, 16, 1'b0);         // sw timeout
        run_instr(6'h00, 6'h2A, 16, 0, 1'b0);         // fetch timeout then re-fetch
        run_instr(6'h23, 6'h00, 15, 15, 1'b0);        // ready on the last allowed cycle
        run_instr(6'h23, 6'h00, 1, 16, 1'b0);         // lw timeout, no writeback

        // sw interrupted by reset while waiting on memory
        mem_access(0, 0, "fetch", done);
        opcode = 6'h2B; funct = 6'h00;
        e = '0; e.alu_src_b = 2'b11;
        do_cycle(e, 1'b0, 1'b0, "decode");
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        do_cycle(e, 1'b0, 1'b0, "addr");
        e = '0; e.mem_req = 1'b1; e.mem_write = 1'b1; e.i_or_d = 1'b1;
        repeat (3) do_cycle(e, 1'b0, 1'b0, "mem_wr_wait");
        reset_n = 1'b0;
        do_cycle('0, 1'b1, 1'b1, "reset_mid");
        reset_n = 1'b1;
        do_cycle('0, 1'b1, 1'b0, "start_again");

        for (int i = 0; i < 200; i++) begin
            r  = int'($urandom_range(0, 9));
            fn = 6'($urandom_range(0, 63));
            if (r < 4)       begin op = 6'h00; fn = r_fns[$urandom_range(0, 9)]; end
            else if (r == 4) op = 6'h23;
            else if (r == 5) op = 6'h2B;
            else if (r < 8)  op = 6'h04;
            else if (r == 8) op = 6'($urandom_range(0, 63));
            else             op = 6'h00;
            run_instr(op, fn, rnd_wait(), rnd_wait(), rbit());
        end

        @(negedge clk);
        #1;
        compared++;
        if (seen_retires != exp_retires) begin
            mismatched++;
            $display("FAIL retire_count: got %0d expected %0d", seen_retires, exp_retires);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
